// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, FSM states,
// datapath select codes and the bundled control-word type.
package multicycle_control_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_I2TYPE = 7'b0000011;  // loads
   localparam logic [6:0] OP_STYPE  = 7'b0100011;
   localparam logic [6:0] OP_BTYPE  = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_LINKWB   = 4'd12,
      S_LUI      = 4'd13,
      S_TRAP     = 4'd14
   } state_e;

   localparam logic [1:0] SRCA_RS1   = 2'b00;
   localparam logic [1:0] SRCA_PC    = 2'b01;
   localparam logic [1:0] SRCA_OLDPC = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_LOAD   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   // States that own a shared-memory request and stall until it completes.
   function automatic logic is_mem_wait(input state_e s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit boundary: instruction/flag inputs from the datapath and memory,
// enables and selects back out to them.
interface multicycle_control_if;

   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic       mem_req;
   logic       mem_we;
   logic       iord;
   logic       ir_write;
   logic       pc_write;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] result_src;
   logic [3:0] state;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, mem_we, iord, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_op, result_src,
             state, instr_done, illegal
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, mem_we, iord, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, alu_op, result_src,
             state, instr_done, illegal
   );

endinterface

// File: rtl/multicycle_control_next_state.sv
// Combinational next-state function of the control FSM, plus the branch-taken
// decision that depends on the same state/flag inputs.
module mc_next_state
   import multicycle_control_pkg::*;
(
   input  state_e     state_i,
   input  logic [6:0] opcode_i,
   input  logic       mem_ready_i,
   input  logic       zero_i,
   output state_e     next_o,
   output logic       taken_o
);

   always_comb begin
      next_o  = S_TRAP;
      taken_o = (state_i == S_BRANCH) && zero_i;

      if (is_mem_wait(state_i) && !mem_ready_i) begin
         next_o = state_i;
      end else begin
         case (state_i)
            S_FETCH:  next_o = S_DECODE;
            S_DECODE: begin
               case (opcode_i)
                  OP_I2TYPE,
                  OP_STYPE:  next_o = S_MEMADR;
                  OP_RTYPE:  next_o = S_EXECR;
                  OP_ITYPE:  next_o = S_EXECI;
                  OP_BTYPE:  next_o = S_BRANCH;
                  OP_JAL:    next_o = S_JAL;
                  OP_JALR:   next_o = S_JALR;
                  OP_LUI:    next_o = S_LUI;
                  OP_AUIPC:  next_o = S_ALUWB;
                  default:   next_o = S_TRAP;
               endcase
            end
            S_MEMADR: begin
               if (opcode_i == OP_I2TYPE) begin
                  next_o = S_MEMREAD;
               end else if (opcode_i == OP_STYPE) begin
                  next_o = S_MEMWRITE;
               end else begin
                  next_o = S_TRAP;
               end
            end
            S_MEMREAD:  next_o = S_MEMWB;
            S_MEMWB:    next_o = S_FETCH;
            S_MEMWRITE: next_o = S_FETCH;
            S_EXECR:    next_o = S_ALUWB;
            S_EXECI:    next_o = S_ALUWB;
            S_LUI:      next_o = S_ALUWB;
            S_ALUWB:    next_o = S_FETCH;
            S_BRANCH:   next_o = S_FETCH;
            S_JAL:      next_o = S_LINKWB;
            S_JALR:     next_o = S_LINKWB;
            S_LINKWB:   next_o = S_FETCH;
            S_TRAP:     next_o = S_TRAP;  // sticky until reset
            default:    next_o = S_TRAP;  // unused encoding 15
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables and operand/result selects from the state.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   multicycle_control_if.master       bus
);

   state_e state_q;
   state_e state_d;
   logic   br_taken;
   ctrl_t  ctrl;

   mc_next_state u_next_state (
      .state_i     (state_q),
      .opcode_i    (bus.opcode),
      .mem_ready_i (bus.mem_ready),
      .zero_i      (bus.zero),
      .next_o      (state_d),
      .taken_o     (br_taken)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Everything is held at zero while reset is asserted so an in-flight memory
   // request is dropped in the same cycle reset arrives.
   always_comb begin
      ctrl = '0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               ctrl.mem_req    = 1'b1;
               ctrl.alu_src_a  = SRCA_PC;
               ctrl.alu_src_b  = SRCB_FOUR;
               ctrl.alu_op     = ALUOP_ADD;
               ctrl.result_src = RES_ALU;
               ctrl.ir_write   = bus.mem_ready;
               ctrl.pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
               ctrl.alu_src_a  = SRCA_OLDPC;
               ctrl.alu_src_b  = SRCB_IMM;
               ctrl.alu_op     = ALUOP_ADD;
            end
            S_MEMADR: begin
               ctrl.alu_src_a  = SRCA_RS1;
               ctrl.alu_src_b  = SRCB_IMM;
               ctrl.alu_op     = ALUOP_ADD;
            end
            S_MEMREAD: begin
               ctrl.mem_req    = 1'b1;
               ctrl.iord       = 1'b1;
            end
            S_MEMWB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.result_src = RES_LOAD;
               ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
               ctrl.mem_req    = 1'b1;
               ctrl.mem_we     = 1'b1;
               ctrl.iord       = 1'b1;
               ctrl.instr_done = bus.mem_ready;
            end
            S_EXECR: begin
               ctrl.alu_src_a  = SRCA_RS1;
               ctrl.alu_src_b  = SRCB_RS2;
               ctrl.alu_op     = ALUOP_FUNCT;
            end
            S_EXECI: begin
               ctrl.alu_src_a  = SRCA_RS1;
               ctrl.alu_src_b  = SRCB_IMM;
               ctrl.alu_op     = ALUOP_FUNCT;
            end
            S_LUI: begin
               ctrl.alu_src_a  = SRCA_ZERO;
               ctrl.alu_src_b  = SRCB_IMM;
               ctrl.alu_op     = ALUOP_ADD;
            end
            S_ALUWB: begin
               ctrl.reg_write  = 1'b1;
               ctrl.result_src = RES_ALUOUT;
               ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
               ctrl.alu_src_a  = SRCA_RS1;
               ctrl.alu_src_b  = SRCB_RS2;
               ctrl.alu_op     = ALUOP_BRANCH;
               ctrl.result_src = RES_ALUOUT;
               ctrl.pc_write   = br_taken;
               ctrl.instr_done = 1'b1;
            end
            S_JAL: begin
               ctrl.result_src = RES_ALUOUT;  // target computed in DECODE
               ctrl.pc_write   = 1'b1;
            end
            S_JALR: begin
               ctrl.alu_src_a  = SRCA_RS1;
               ctrl.alu_src_b  = SRCB_IMM;
               ctrl.alu_op     = ALUOP_ADD;
               ctrl.result_src = RES_ALU;
               ctrl.pc_write   = 1'b1;
            end
            S_LINKWB: begin
               ctrl.alu_src_a  = SRCA_OLDPC;
               ctrl.alu_src_b  = SRCB_FOUR;
               ctrl.alu_op     = ALUOP_ADD;
               ctrl.result_src = RES_ALU;
               ctrl.reg_write  = 1'b1;
               ctrl.instr_done = 1'b1;
            end
            S_TRAP: begin
               ctrl.illegal    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_req    = ctrl.mem_req;
   assign bus.mem_we     = ctrl.mem_we;
   assign bus.iord       = ctrl.iord;
   assign bus.ir_write   = ctrl.ir_write;
   assign bus.pc_write   = ctrl.pc_write;
   assign bus.reg_write  = ctrl.reg_write;
   assign bus.alu_src_a  = ctrl.alu_src_a;
   assign bus.alu_src_b  = ctrl.alu_src_b;
   assign bus.alu_op     = ctrl.alu_op;
   assign bus.result_src = ctrl.result_src;
   assign bus.instr_done = ctrl.instr_done;
   assign bus.illegal    = ctrl.illegal;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction state paths and
// per-state control words come from a behavioural model of the instruction flow.
module tb_multicycle_control;

   logic clk = 1'b0;
   logic rst;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LOAD   = 7'h03;
   localparam logic [6:0] STORE  = 7'h23;
   localparam logic [6:0] RTYP   = 7'h33;
   localparam logic [6:0] ITYP   = 7'h13;
   localparam logic [6:0] BRAN   = 7'h63;
   localparam logic [6:0] JALO   = 7'h6F;
   localparam logic [6:0] JALRO  = 7'h67;
   localparam logic [6:0] LUIO   = 7'h37;
   localparam logic [6:0] AUIPCO = 7'h17;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] op;
      logic [1:0] rs;
      logic       done;
      logic       illegal;
   } outs_t;

   int n_tests = 0;
   int n_fail  = 0;
   int path[$];

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic outs_t observe();
      outs_t o;
      o = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write, bus.reg_write,
           bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src, bus.instr_done, bus.illegal};
      return o;
   endfunction

   // Control word each step of the instruction flow should present.
   function automatic outs_t expect_outs(input int s, input bit mr, input bit z);
      outs_t e;
      e = '0;
      case (s)
         0:  begin e.mem_req = 1; e.a = 2'd1; e.b = 2'd2; e.rs = 2'd2; e.ir_write = mr; e.pc_write = mr; end
         1:  begin e.a = 2'd2; e.b = 2'd1; end
         2:  begin e.b = 2'd1; end
         3:  begin e.mem_req = 1; e.iord = 1; end
         4:  begin e.reg_write = 1; e.rs = 2'd1; e.done = 1; end
         5:  begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; e.done = mr; end
         6:  begin e.op = 2'd2; end
         7:  begin e.b = 2'd1; e.op = 2'd2; end
         8:  begin e.reg_write = 1; e.done = 1; end
         9:  begin e.op = 2'd1; e.pc_write = z; e.done = 1; end
         10: begin e.pc_write = 1; end
         11: begin e.b = 2'd1; e.rs = 2'd2; e.pc_write = 1; end
         12: begin e.a = 2'd2; e.b = 2'd2; e.rs = 2'd2; e.reg_write = 1; e.done = 1; end
         13: begin e.a = 2'd3; e.b = 2'd1; end
         14: begin e.illegal = 1; end
         default: ;
      endcase
      return e;
   endfunction

   // Sequence of steps an instruction walks through, by instruction class.
   function automatic void build_path(input logic [6:0] op);
      path = {0, 1};
      case (op)
         LOAD:    path = {path, 2, 3, 4};
         STORE:   path = {path, 2, 5};
         RTYP:    path = {path, 6, 8};
         ITYP:    path = {path, 7, 8};
         BRAN:    path = {path, 9};
         JALO:    path = {path, 10, 12};
         JALRO:   path = {path, 11, 12};
         LUIO:    path = {path, 13, 8};
         AUIPCO:  path = {path, 8};
         default: path = {path, 14};
      endcase
   endfunction

   // zmode: 0/1 force the branch flag, 2 randomizes it every cycle.
   task automatic run_instr(input logic [6:0] op, input bit always_ready, input int zmode,
                            output int cycles);
      int  idx;
      int  trap_n;
      int  s;
      bit  mr;
      bit  z;
      idx    = 0;
      trap_n = 0;
      cycles = 0;
      build_path(op);
      bus.opcode = op;
      forever begin
         @(negedge clk);
         mr = always_ready ? 1'b1 : ($urandom_range(0, 3) != 0);
         z  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         bus.mem_ready = mr;
         bus.zero      = z;
         #2;
         s = path[idx];
         chk("state", 32'(bus.state), 32'(s));
         chk("outs", 32'(observe()), 32'(expect_outs(s, mr, z)));
         cycles++;
         if (cycles > 1000) begin
            chk("instr_timeout", 32'(cycles), 32'd1000);
            break;
         end
         if (s == 14) begin
            trap_n++;
            if (trap_n >= 12) break;
            continue;
         end
         if ((s == 0 || s == 3 || s == 5) && !mr) continue;
         if (idx == path.size() - 1) break;
         idx++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_illegal", 32'(bus.illegal), 32'd0);
      chk("rst_outs", 32'(observe()), 32'd0);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      rst = 1'b0;
      #2;
      chk("post_rst_state", 32'(bus.state), 32'd0);
      chk("post_rst_mem_req", 32'(bus.mem_req), 32'd1);
      chk("post_rst_iord", 32'(bus.iord), 32'd0);
   endtask

   logic [6:0] ops  [9] = '{RTYP, ITYP, LUIO, JALO, JALRO, STORE, LOAD, BRAN, AUIPCO};
   int         lats [9] = '{4, 4, 4, 4, 4, 4, 5, 3, 3};

   initial begin
      int         c;
      logic [6:0] op;
      logic [31:0] add_instr;

      bus.opcode    = 7'h00;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      rst           = 1'b1;

      #12;
      chk("init_state", 32'(bus.state), 32'd0);
      chk("init_outs", 32'(observe()), 32'd0);
      bus.mem_ready = 1'b1;
      #1;
      chk("init_outs_ready", 32'(observe()), 32'd0);
      do_reset();

      add_instr = 32'h002081B3;
      run_instr(add_instr[6:0], 1'b1, 2, c);
      chk("add_latency", 32'(c), 32'd4);

      for (int i = 0; i < 9; i++) begin
         run_instr(ops[i], 1'b1, 2, c);
         chk("latency", 32'(c), 32'(lats[i]));
      end

      run_instr(BRAN, 1'b1, 1, c);
      chk("beq_taken_latency", 32'(c), 32'd3);
      run_instr(BRAN, 1'b1, 0, c);
      chk("beq_not_taken_latency", 32'(c), 32'd3);

      run_instr(7'h7F, 1'b0, 2, c);
      do_reset();

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            op = 7'($urandom);
         end else begin
            op = ops[$urandom_range(0, 8)];
         end
         run_instr(op, 1'b0, 2, c);
         if (path[path.size() - 1] == 14) do_reset();
      end

      bus.opcode = STORE;
      repeat (3) begin
         @(negedge clk);
         bus.mem_ready = 1'b1;
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #2;
      chk("mw_state", 32'(bus.state), 32'd5);
      chk("mw_mem_req", 32'(bus.mem_req), 32'd1);
      do_reset();

      run_instr(LOAD, 1'b0, 2, c);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have: opcode  input  7  instr[6:0] from the instruction register.
REQ-004 SHALL have: zero  input  1  ALU branch-condition flag (ALUCtrl folds funct3 into it).
REQ-005 SHALL have: mem_ready  input  1  shared memory completes the current request this cycle.
REQ-006 SHALL have: mem_req / mem_we / iord  output  1 each  memory request, write enable, address select (0=PC, 1=ALUOut).
REQ-007 SHALL have: ir_write / pc_write / reg_write  output  1 each  IR, PC and register-file write enables.
REQ-008 SHALL have: alu_src_a  output  2  00=rs1, 01=PC, 10=oldPC, 11=zero.
REQ-009 SHALL have: alu_src_b  output  2  00=rs2, 01=imm, 10=constant 4.
REQ-010 SHALL have: alu_op  output  2  00=add, 01=branch compare, 10=funct-decoded.
REQ-011 SHALL have: result_src  output  2  00=ALUOut register, 01=load data, 10=ALU result.
REQ-012 SHALL have: state  output  4, instr_done  output  1, illegal  output  1.

Function
REQ-013 SHALL be a 15-state FSM: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, LINKWB 12, LUI 13, TRAP 14; encoding 15 SHALL go to TRAP.
REQ-014 FETCH: mem_req=1, iord=0, alu PC+4 (result_src 10). Holds until mem_ready; in the mem_ready cycle ir_write=1 and pc_write=1, then DECODE.
REQ-015 DECODE: alu oldPC+imm, add (target latched in ALUOut). Next state by opcode: load/store->MEMADR, RTYPE->EXECR, ITYPE->EXECI, BTYPE->BRANCH, JAL->JAL, JALR->JALR, LUI->LUI, AUIPC->ALUWB, other->TRAP.
REQ-016 MEMADR: rs1+imm, add. Next state: load->MEMREAD, store->MEMWRITE.
REQ-017 MEMREAD: mem_req=1, iord=1; holds until mem_ready, then MEMWB. MEMWB: reg_write=1, result_src=01, then FETCH.
REQ-018 MEMWRITE: mem_req=1, mem_we=1, iord=1; holds until mem_ready, then FETCH.
REQ-019 EXECR: rs1 op rs2. EXECI: rs1 op imm. Both use alu_op 10 and go to ALUWB. LUI: zero+imm, add, then ALUWB. ALUWB: reg_write=1, result_src=00, then FETCH.
REQ-020 BRANCH: rs1 vs rs2, alu_op 01, result_src 00; pc_write=zero; then FETCH.
REQ-021 JAL: pc_write=1, result_src=00, then LINKWB. JALR: rs1+imm, result_src=10, pc_write=1, then LINKWB.
REQ-022 LINKWB: oldPC+4, result_src=10, reg_write=1, then FETCH.
REQ-023 TRAP: illegal=1; all write enables and mem_req SHALL be 0; TRAP is sticky until rst.
REQ-024 Outputs SHALL be a function of state only, except: ir_write and pc_write in FETCH (gated by mem_ready), pc_write in BRANCH (zero), and instr_done.
REQ-025 mem_req, mem_we and iord SHALL stay constant for every cycle of a wait.
REQ-026 instr_done SHALL pulse 1 cycle in the final cycle of each instruction: MEMWB, ALUWB, BRANCH, LINKWB, or MEMWRITE when mem_ready=1.
REQ-027 Latency with mem_ready tied 1 SHALL be: branch 3, AUIPC 3, R/I/LUI/JAL/JALR/store 4, load 5 cycles.
REQ-028 Unassigned selects SHALL drive 0.

Reset
REQ-029 rst=1 SHALL asynchronously force state=FETCH and illegal=0. All enables SHALL be 0 while rst is high; selects SHALL be 0.
REQ-030 rst asserted during a memory wait SHALL abandon the request. After release, the first cycle SHALL be FETCH with mem_req=1, iord=0.

Structure
REQ-031 Opcode constants (RTYPE, ITYPE, I2TYPE, STYPE, BTYPE, JAL, JALR, LUI, AUIPC), state encodings and select encodings SHALL live in the shared parameters file.
REQ-032 The block SHALL have one sub-module, mc_next_state: a combinational next-state function of state, opcode, mem_ready and zero.

Verification
REQ-033 add x3,x1,x2 (0x002081B3) with mem_ready=1 -> states 0,1,6,8; reg_write only in state 8; instr_done in cycle 4.
REQ-034 lw (opcode 0000011) with mem_ready low 3 cycles in MEMREAD -> state 3 held 4 cycles with constant mem_req=1/iord=1, then MEMWB with result_src=01.
REQ-035 beq, zero=1 vs zero=0 -> pc_write=1 in BRANCH only when zero=1; both take 3 cycles.
REQ-036 jalr -> JALR pc_write=1 with result_src=10, then LINKWB reg_write=1 with alu_src_a=10, alu_src_b=10.
REQ-037 opcode 0x7F -> TRAP, illegal=1; holds through 10 cycles with no writes; rst clears it to FETCH.
REQ-038 rst pulsed mid-MEMWRITE wait -> mem_req drops immediately; after release, state=FETCH.
